// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gating sequencer: gates idle domains after IDLE_CYCLES,
// restores the enable on demand and holds ready off for WAKE_CYCLES settle cycles.
module clk_gate_ctrl #(
  parameter int unsigned N_DOMAINS   = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 force_on_i,
  input  logic [N_DOMAINS-1:0] allow_i,
  input  logic [N_DOMAINS-1:0] busy_i,
  input  logic [N_DOMAINS-1:0] wake_i,
  output logic [N_DOMAINS-1:0] clk_en_o,
  output logic [N_DOMAINS-1:0] ready_o,
  output logic                 all_gated_o
);

  localparam int unsigned MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFF  = 2'd2,
    ST_WAKE = 2'd3
  } state_e;

  logic all_gated_q, all_gated_d;

  for (genvar g = 0; g < int'(N_DOMAINS); g++) begin : g_dom
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             rdy_q, rdy_d;
    logic             idle_c;
    logic             wake_c;

    assign idle_c = ~busy_i[g] & ~wake_i[g] & allow_i[g] & ~force_on_i;
    assign wake_c = busy_i[g] | wake_i[g] | ~allow_i[g] | force_on_i;

    // Next-state: enable and ready are computed here and land in their own flops.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      rdy_d   = rdy_q;
      case (state_q)
        ST_RUN: begin
          if (idle_c) begin
            if (IDLE_CYCLES == 1) begin
              state_d = ST_OFF;
              cnt_d   = '0;
              en_d    = 1'b0;
              rdy_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_IDLE: begin
          if (!idle_c) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (cnt_q == IDLE_LAST) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            en_d    = 1'b0;
            rdy_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (wake_c) begin
            en_d  = 1'b1;
            cnt_d = '0;
            if (WAKE_CYCLES == 0) begin
              state_d = ST_RUN;
              rdy_d   = 1'b1;
            end else begin
              state_d = ST_WAKE;
            end
          end
        end
        ST_WAKE: begin
          // Settling cannot be aborted; idle is ignored here.
          if (cnt_q == WAKE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            rdy_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
          en_d    = 1'b1;
          rdy_d   = 1'b1;
        end
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_RUN;
        cnt_q   <= '0;
        en_q    <= 1'b1;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        en_q    <= en_d;
        rdy_q   <= rdy_d;
      end
    end

    assign clk_en_o[g] = en_q;
    assign ready_o[g]  = rdy_q;
  end

  // Registered from the enable flops, so it follows the last enable by one edge.
  assign all_gated_d = ~|clk_en_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      all_gated_q <= 1'b0;
    end else begin
      all_gated_q <= all_gated_d;
    end
  end

  assign all_gated_o = all_gated_q;

endmodule
